rr_lock_arbiter: RTL and testbench
==================================

RR_LOCK_ARBITER -- requirements
Module: rr_lock_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 16, maximum grant tenure in cycles (legal 0..255); 0 disables the tenure limit.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; all state cleared while low.
REQ-004 req  input  4  per-requester request level; bit i = requester i.
REQ-005 release  input  4  per-requester release pulse; only the bit of the current owner is honoured.
REQ-006 grant  output  4  registered one-hot grant; all-zero when no owner.
REQ-007 grant_id  output  2  index of current owner; 0 when grant is all-zero.
REQ-008 ptr  output  2  current round-robin priority pointer, i.e. the highest-priority index for the next arbitration.
REQ-009 timeout  output  1  single-cycle pulse when a tenure is ended by MAX_HOLD expiry.

Function
REQ-010 FSM states IDLE, OWN, GAP; reset state IDLE.
REQ-011 IDLE: if req != 0, select a winner, register grant/grant_id, go to OWN; grant visible the cycle after req is sampled (latency 1).
REQ-012 IDLE with req == 0: stay in IDLE; grant = 0.
REQ-013 Selection: masked_req = req & mask(ptr), where mask(0)=1111, mask(1)=1110, mask(2)=1100, mask(3)=1000; winner = lowest set bit of masked_req.
REQ-014 Selection fallback: if masked_req == 0, winner = lowest set bit of unmasked req (wrap-around).
REQ-015 OWN: grant held constant, hold counter (8-bit) increments each cycle starting from 1 on the first OWN cycle.
REQ-016 OWN exits to GAP when release[grant_id]=1, or req[grant_id]=0, or (MAX_HOLD != 0 and counter == MAX_HOLD).
REQ-017 timeout pulses high for the one cycle in which OWN exits due to counter expiry alone; release or req drop in the same cycle takes precedence and suppresses timeout.
REQ-018 release bits of non-owners are ignored in every state; release in IDLE or GAP has no effect.
REQ-019 On OWN exit, ptr <= (grant_id + 1) mod 4 (2-bit wrap, 3 -> 0), counter cleared.
REQ-020 GAP: exactly one cycle, grant = 0, grant_id = 0, then IDLE; a new grant therefore appears no earlier than 2 cycles after the previous one ends.
REQ-021 Requests asserted or dropped during OWN by non-owners do not alter the current grant.
REQ-022 grant is never multi-hot; grant is never nonzero in IDLE or GAP.

Reset
REQ-023 While reset is low: state IDLE, grant=0000, grant_id=0, ptr=0, timeout=0, counter=0, immediately (asynchronous), including mid-tenure.
REQ-024 After reset deasserts, the first arbitration uses ptr=0 (mask 1111).

Verification
REQ-025 Reset, req=0110 held, release never asserted, MAX_HOLD=4 -> grant=0010 for 4 cycles, timeout pulse on 4th, GAP, ptr=2, then grant=0100.
REQ-026 ptr=3, req=0011 -> masked empty, fallback grant=0001, grant_id=0; on release[0], ptr becomes 1.
REQ-027 Owner 2 holding, release=1011 (owner bit clear) -> grant unchanged; release=0100 -> grant 0 next cycle, ptr=3.
REQ-028 MAX_HOLD=4, release[owner] asserted on the 4th OWN cycle -> tenure ends, timeout stays 0.
REQ-029 All four requesting continuously with release after 1 cycle each -> grants 0001,0010,0100,1000,0001 in order, each separated by one zero GAP cycle.
REQ-030 reset driven low mid-OWN with grant=1000 -> grant=0000, ptr=0 without waiting for a clock edge; after release of reset with req=1000, grant=1000 one cycle later.

Source files
------------

// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter
// ---------------
// Four-requester round-robin arbiter with locked ownership. Once a requester
// wins, the grant is held until the owner releases it, drops its request, or
// (when MAX_HOLD is nonzero) the tenure reaches MAX_HOLD cycles. Every tenure
// is followed by a one-cycle GAP with no grant before arbitration resumes.
//
// Handshake: req is a level. A requester keeps its req bit high for as long
// as it wants the resource. grant is registered and one-hot; a requester owns
// the resource in every cycle its grant bit is high. release_pulse is a
// one-cycle strobe sampled only from the current owner; release bits of
// non-owners, or any release bit outside a tenure, are ignored.
//
// Ports
//   clk            sole clock, rising edge
//   reset          asynchronous, active-low reset
//   req[3:0]       request level, bit i = requester i
//   release_pulse  release strobe, bit i = requester i ("release" is a
//                  reserved word in SystemVerilog, hence the longer name)
//   grant[3:0]     registered one-hot grant, zero when nobody owns
//   grant_id[1:0]  index of the current owner, zero when grant is zero
//   ptr[1:0]       round-robin pointer: highest-priority index next time
//   timeout        high during the OWN cycle that ends on tenure expiry
//   state_dbg[1:0] FSM state (0 IDLE, 1 OWN, 2 GAP)

module rr_lock_arbiter #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req,
   input  logic [3:0] release_pulse,
   output logic [3:0] grant,
   output logic [1:0] grant_id,
   output logic [1:0] ptr,
   output logic       timeout,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN  = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
   localparam bit         LIMIT_EN   = (MAX_HOLD != 0);

   state_t     state, state_n;
   logic [3:0] grant_n;
   logic [1:0] grant_id_n;
   logic [1:0] ptr_n;
   logic [7:0] hold_cnt, hold_cnt_n;

   logic [3:0] mask;
   logic [3:0] masked_req;
   logic [1:0] win_id;
   logic       owner_rel;
   logic       owner_req;
   logic       expire;

   function automatic logic [1:0] lowest_set(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      if (v[0])      idx = 2'd0;
      else if (v[1]) idx = 2'd1;
      else if (v[2]) idx = 2'd2;
      else if (v[3]) idx = 2'd3;
      return idx;
   endfunction

   // Priority mask: indices below ptr are excluded on the first pass; if
   // nothing survives the mask the search wraps to the full request vector.
   always_comb begin
      mask = 4'b1111;
      case (ptr)
         2'd0: mask = 4'b1111;
         2'd1: mask = 4'b1110;
         2'd2: mask = 4'b1100;
         2'd3: mask = 4'b1000;
         default: mask = 4'b1111;
      endcase
      masked_req = req & mask;
      win_id     = (masked_req != 4'b0000) ? lowest_set(masked_req) : lowest_set(req);
   end

   assign owner_rel = release_pulse[grant_id];
   assign owner_req = req[grant_id];
   assign expire    = LIMIT_EN && (hold_cnt == HOLD_LIMIT);

   always_comb begin
      state_n    = state;
      grant_n    = grant;
      grant_id_n = grant_id;
      ptr_n      = ptr;
      hold_cnt_n = hold_cnt;
      timeout    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req != 4'b0000) begin
               state_n    = ST_OWN;
               grant_n    = 4'b0001 << win_id;
               grant_id_n = win_id;
               hold_cnt_n = 8'd1;
            end
         end
         ST_OWN: begin
            if (owner_rel || !owner_req || expire) begin
               state_n    = ST_GAP;
               grant_n    = 4'b0000;
               grant_id_n = 2'd0;
               ptr_n      = grant_id + 2'd1;
               hold_cnt_n = 8'd0;
               // Release or request drop wins over expiry in the same cycle.
               timeout    = expire && !owner_rel && owner_req;
            end else begin
               hold_cnt_n = hold_cnt + 8'd1;
            end
         end
         ST_GAP: begin
            state_n = ST_IDLE;
         end
         default: begin
            state_n    = ST_IDLE;
            grant_n    = 4'b0000;
            grant_id_n = 2'd0;
            hold_cnt_n = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         grant    <= 4'b0000;
         grant_id <= 2'd0;
         ptr      <= 2'd0;
         hold_cnt <= 8'd0;
      end else begin
         state    <= state_n;
         grant    <= grant_n;
         grant_id <= grant_id_n;
         ptr      <= ptr_n;
         hold_cnt <= hold_cnt_n;
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter with MAX_HOLD = 4.
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// on the falling edge, so grant shows the state left by the previous edge
// and timeout reflects the inputs of the current cycle.

module tb_rr_lock_arbiter;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_OWN  = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   logic       clk;
   logic       reset;
   logic [3:0] req;
   logic [3:0] release_pulse;
   logic [3:0] grant;
   logic [1:0] grant_id;
   logic [1:0] ptr;
   logic       timeout;
   logic [1:0] state_dbg;

   int n_checks = 0;
   int n_errors = 0;
   logic [3:0] exp_q[$];
   logic [3:0] exp_g;

   rr_lock_arbiter #(.MAX_HOLD(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .req           (req),
      .release_pulse (release_pulse),
      .grant         (grant),
      .grant_id      (grant_id),
      .ptr           (ptr),
      .timeout       (timeout),
      .state_dbg     (state_dbg)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // watchdog
   initial begin
      #20000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "bench did not finish");
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle: drive inputs just after the edge, move to the check point.
   task automatic cyc(input logic [3:0] r, input logic [3:0] rl);
      @(posedge clk);
      #1;
      req           = r;
      release_pulse = rl;
      @(negedge clk);
   endtask

   task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] gid,
                          input logic [1:0] p, input logic to, input logic [1:0] st);
      chk({tag, ".grant"},    {4'd0, grant},    {4'd0, g});
      chk({tag, ".grant_id"}, {6'd0, grant_id}, {6'd0, gid});
      chk({tag, ".ptr"},      {6'd0, ptr},      {6'd0, p});
      chk({tag, ".timeout"},  {7'd0, timeout},  {7'd0, to});
      chk({tag, ".state"},    {6'd0, state_dbg}, {6'd0, st});
   endtask

   initial begin
      reset         = 1'b0;
      req           = 4'b0000;
      release_pulse = 4'b0000;
      #3;
      chk_all("reset", 4'b0000, 2'd0, 2'd0, 1'b0, S_IDLE);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      chk_all("post_reset", 4'b0000, 2'd0, 2'd0, 1'b0, S_IDLE);

      // Tenure expiry: req 0110 held, ptr 0 -> requester 1 owns for 4 cycles
      cyc(4'b0110, 4'b0000);
      chk_all("exp_idle", 4'b0000, 2'd0, 2'd0, 1'b0, S_IDLE);
      for (int i = 1; i <= 4; i++) begin
         cyc(4'b0110, 4'b0000);
         chk_all($sformatf("exp_own%0d", i), 4'b0010, 2'd1, 2'd0, (i == 4), S_OWN);
      end
      cyc(4'b0110, 4'b0000);
      chk_all("exp_gap", 4'b0000, 2'd0, 2'd2, 1'b0, S_GAP);
      cyc(4'b0110, 4'b0000);
      chk_all("exp_idle2", 4'b0000, 2'd0, 2'd2, 1'b0, S_IDLE);
      cyc(4'b0110, 4'b0000);
      chk_all("exp_next", 4'b0100, 2'd2, 2'd2, 1'b0, S_OWN);

      // Owner 2: non-owner releases and request changes are ignored
      cyc(4'b1111, 4'b1011);
      chk_all("own2_ignore", 4'b0100, 2'd2, 2'd2, 1'b0, S_OWN);
      cyc(4'b0101, 4'b0100);
      chk_all("own2_rel", 4'b0100, 2'd2, 2'd2, 1'b0, S_OWN);
      cyc(4'b0011, 4'b1111);
      chk_all("own2_gap", 4'b0000, 2'd0, 2'd3, 1'b0, S_GAP);

      // ptr 3 with req 0011: mask leaves nothing, wrap to requester 0
      cyc(4'b0011, 4'b1111);
      chk_all("wrap_idle", 4'b0000, 2'd0, 2'd3, 1'b0, S_IDLE);
      cyc(4'b0011, 4'b0000);
      chk_all("wrap_own", 4'b0001, 2'd0, 2'd3, 1'b0, S_OWN);
      cyc(4'b0011, 4'b0001);
      chk_all("wrap_rel", 4'b0001, 2'd0, 2'd3, 1'b0, S_OWN);
      cyc(4'b0000, 4'b1111);
      chk_all("wrap_gap", 4'b0000, 2'd0, 2'd1, 1'b0, S_GAP);
      cyc(4'b0000, 4'b1111);
      chk_all("idle_rel", 4'b0000, 2'd0, 2'd1, 1'b0, S_IDLE);

      // Owner drops its request: tenure ends, no timeout
      cyc(4'b0100, 4'b0000);
      chk_all("drop_idle", 4'b0000, 2'd0, 2'd1, 1'b0, S_IDLE);
      cyc(4'b0000, 4'b0000);
      chk_all("drop_own", 4'b0100, 2'd2, 2'd1, 1'b0, S_OWN);
      cyc(4'b0000, 4'b0000);
      chk_all("drop_gap", 4'b0000, 2'd0, 2'd3, 1'b0, S_GAP);

      // Release on the 4th cycle coincides with expiry: timeout suppressed
      cyc(4'b1000, 4'b0000);
      chk_all("relx_idle", 4'b0000, 2'd0, 2'd3, 1'b0, S_IDLE);
      for (int i = 1; i <= 4; i++) begin
         cyc(4'b1000, (i == 4) ? 4'b1000 : 4'b0000);
         chk_all($sformatf("relx_own%0d", i), 4'b1000, 2'd3, 2'd3, 1'b0, S_OWN);
      end
      cyc(4'b1000, 4'b0000);
      chk_all("relx_gap", 4'b0000, 2'd0, 2'd0, 1'b0, S_GAP);

      // All four requesting, each owner releases after one cycle
      exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      cyc(4'b1111, 4'b0000);
      chk_all("rr_idle", 4'b0000, 2'd0, 2'd0, 1'b0, S_IDLE);
      while (exp_q.size() > 0) begin
         exp_g = exp_q.pop_front();
         cyc(4'b1111, exp_g);
         chk("rr_grant", {4'd0, grant}, {4'd0, exp_g});
         cyc(4'b1111, 4'b0000);
         chk("rr_gap", {4'd0, grant}, 8'd0);
         cyc(4'b1111, 4'b0000);
         chk("rr_idle_gap", {4'd0, grant}, 8'd0);
      end

      // Asynchronous reset in the middle of a tenure by requester 3
      cyc(4'b1000, 4'b0000);
      chk_all("ar_own1", 4'b0010, 2'd1, 2'd1, 1'b0, S_OWN);
      cyc(4'b1000, 4'b0000);
      chk_all("ar_gap", 4'b0000, 2'd0, 2'd2, 1'b0, S_GAP);
      cyc(4'b1000, 4'b0000);
      chk_all("ar_idle", 4'b0000, 2'd0, 2'd2, 1'b0, S_IDLE);
      cyc(4'b1000, 4'b0000);
      chk_all("ar_own3", 4'b1000, 2'd3, 2'd2, 1'b0, S_OWN);
      cyc(4'b1000, 4'b0000);
      chk_all("ar_own3b", 4'b1000, 2'd3, 2'd2, 1'b0, S_OWN);
      #2;
      reset = 1'b0;
      #1;
      chk_all("ar_async", 4'b0000, 2'd0, 2'd0, 1'b0, S_IDLE);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      chk_all("ar_held", 4'b0000, 2'd0, 2'd0, 1'b0, S_IDLE);
      cyc(4'b1000, 4'b0000);
      chk_all("ar_regrant", 4'b1000, 2'd3, 2'd0, 1'b0, S_OWN);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
